// File: rtl/hash_table_v3.sv
// rtl/hash_table_v3.sv - bucketed multi-match hash table with build overflow reporting
module hash_table_v3 #(
  parameter int ROW_BITS    = 3,
  parameter int SLOTS       = 4,
  parameter int TUPLE_BITS  = 64,
  parameter int KEY_BITS    = 32,
  parameter int SERIAL_BITS = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid_BUILD,
  output logic                    in_ready_BUILD,
  input  logic [TUPLE_BITS-1:0]   in_data_BUILD,
  input  logic [31:0]             in_hash_BUILD,
  input  logic                    in_last_processed_BUILD,
  input  logic                    in_valid_PROBE,
  output logic                    in_ready_PROBE,
  input  logic [TUPLE_BITS-1:0]   in_data_PROBE,
  input  logic [31:0]             in_hash_PROBE,
  input  logic [SERIAL_BITS-1:0]  in_serialnum,
  input  logic                    in_last_processed_PROBE,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*TUPLE_BITS-1:0] out_data,
  output logic [SERIAL_BITS-1:0]  out_serialnum,
  output logic                    out_was_joined,
  output logic                    out_last_processed,
  output logic                    overflow,
  output logic [31:0]             overflow_count
);
  localparam int NUM_ROWS = 2**ROW_BITS;
  localparam int CNT_W    = $clog2(SLOTS+1);
  localparam int DATA_W   = SLOTS*TUPLE_BITS;
  localparam int ROW_W    = DATA_W + CNT_W;
  localparam int CLR_W    = ROW_BITS + 1;

  typedef enum logic [2:0] {CLEAR, B_IDLE, B_WR, P_IDLE, P_LOOK, P_EMIT, DONE} state_t;

  logic [ROW_W-1:0] mem [NUM_ROWS];
  logic [ROW_W-1:0] rdata_q;

  state_t                  state_q, state_d;
  logic [CLR_W-1:0]        clr_q, clr_d;
  logic [ROW_BITS-1:0]     row_q, row_d;
  logic [TUPLE_BITS-1:0]   tuple_q, tuple_d;
  logic [SERIAL_BITS-1:0]  serial_q, serial_d;
  logic [SLOTS-1:0]        mask_q, mask_d;
  logic                    out_valid_q, out_valid_d;
  logic [2*TUPLE_BITS-1:0] out_data_q, out_data_d;
  logic [SERIAL_BITS-1:0]  out_serial_q, out_serial_d;
  logic                    out_joined_q, out_joined_d;
  logic                    out_last_q, out_last_d;
  logic                    overflow_q, overflow_d;
  logic [31:0]             ovf_cnt_q, ovf_cnt_d;

  logic [ROW_BITS-1:0]     raddr, waddr;
  logic                    mem_we;
  logic [ROW_W-1:0]        wdata;
  logic [CNT_W-1:0]        rd_cnt;
  logic [SLOTS-1:0]        hit, sel, lowest;
  logic [TUPLE_BITS-1:0]   pick_tuple;
  logic                    unused_hash_bits;

  assign unused_hash_bits = ^{in_hash_BUILD[31:ROW_BITS], in_hash_PROBE[31:ROW_BITS]};
  assign rd_cnt = rdata_q[ROW_W-1 -: CNT_W];

  // Read address follows the input hash while idle so row data is ready the cycle after accept
  always_comb begin
    raddr = row_q;
    if (state_q == B_IDLE) raddr = in_hash_BUILD[ROW_BITS-1:0];
    if (state_q == P_IDLE) raddr = in_hash_PROBE[ROW_BITS-1:0];
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < SLOTS; i++)
      hit[i] = (CNT_W'(i) < rd_cnt) &&
               (rdata_q[i*TUPLE_BITS +: KEY_BITS] == tuple_q[KEY_BITS-1:0]);
  end

  always_comb begin
    sel        = (state_q == P_LOOK) ? hit : mask_q;
    lowest     = sel & (~sel + SLOTS'(1));
    pick_tuple = '0;
    for (int i = 0; i < SLOTS; i++)
      if (lowest[i]) pick_tuple = pick_tuple | rdata_q[i*TUPLE_BITS +: TUPLE_BITS];
  end

  always_comb begin
    mem_we = 1'b0;
    waddr  = row_q;
    wdata  = rdata_q;
    if (state_q == CLEAR) begin
      mem_we = (clr_q < CLR_W'(NUM_ROWS));
      waddr  = clr_q[ROW_BITS-1:0];
      wdata  = '0;
    end else if (state_q == B_WR) begin
      mem_we = (rd_cnt < CNT_W'(SLOTS));
      for (int i = 0; i < SLOTS; i++)
        if (CNT_W'(i) == rd_cnt) wdata[i*TUPLE_BITS +: TUPLE_BITS] = tuple_q;
      wdata[ROW_W-1 -: CNT_W] = rd_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  always_comb begin
    state_d      = state_q;
    clr_d        = clr_q;
    row_d        = row_q;
    tuple_d      = tuple_q;
    serial_d     = serial_q;
    mask_d       = mask_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_serial_d = out_serial_q;
    out_joined_d = out_joined_q;
    out_last_d   = (state_q == DONE);
    overflow_d   = overflow_q;
    ovf_cnt_d    = ovf_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_q == CLR_W'(NUM_ROWS)) state_d = B_IDLE;
        else                           clr_d   = clr_q + CLR_W'(1);
      end
      B_IDLE: begin
        if (in_valid_BUILD) begin
          tuple_d = in_data_BUILD;
          row_d   = in_hash_BUILD[ROW_BITS-1:0];
          state_d = B_WR;
        end else if (in_last_processed_BUILD) begin
          state_d = P_IDLE;
        end
      end
      B_WR: begin
        if (rd_cnt >= CNT_W'(SLOTS)) begin
          overflow_d = 1'b1;
          if (ovf_cnt_q != 32'hFFFF_FFFF) ovf_cnt_d = ovf_cnt_q + 32'd1;
        end
        state_d = B_IDLE;
      end
      P_IDLE: begin
        if (in_valid_PROBE) begin
          tuple_d  = in_data_PROBE;
          serial_d = in_serialnum;
          row_d    = in_hash_PROBE[ROW_BITS-1:0];
          state_d  = P_LOOK;
        end else if (in_last_processed_PROBE) begin
          state_d = DONE;
        end
      end
      P_LOOK: begin
        out_valid_d  = 1'b1;
        out_serial_d = serial_q;
        out_joined_d = |hit;
        out_data_d   = {pick_tuple, tuple_q};
        mask_d       = hit & ~lowest;
        state_d      = P_EMIT;
      end
      P_EMIT: begin
        if (out_ready) begin
          if (|mask_q) begin
            out_data_d = {pick_tuple, tuple_q};
            mask_d     = mask_q & ~lowest;
          end else begin
            out_valid_d = 1'b0;
            state_d     = P_IDLE;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= CLEAR;
      clr_q        <= '0;
      row_q        <= '0;
      tuple_q      <= '0;
      serial_q     <= '0;
      mask_q       <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_serial_q <= '0;
      out_joined_q <= 1'b0;
      out_last_q   <= 1'b0;
      overflow_q   <= 1'b0;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      clr_q        <= clr_d;
      row_q        <= row_d;
      tuple_q      <= tuple_d;
      serial_q     <= serial_d;
      mask_q       <= mask_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_serial_q <= out_serial_d;
      out_joined_q <= out_joined_d;
      out_last_q   <= out_last_d;
      overflow_q   <= overflow_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  assign in_ready_BUILD     = (state_q == B_IDLE);
  assign in_ready_PROBE     = (state_q == P_IDLE);
  assign out_valid          = out_valid_q;
  assign out_data           = out_data_q;
  assign out_serialnum      = out_serial_q;
  assign out_was_joined     = out_joined_q;
  assign out_last_processed = out_last_q;
  assign overflow           = overflow_q;
  assign overflow_count     = ovf_cnt_q;
endmodule

// File: doc/hash_table_v3.md
# hash_table_v3

Bucketed hash table for the partitioned hash join: stores build-side tuples in BRAM rows of SLOTS entries and probes them. Unlike the previous table, it emits one output beat per matching slot (multi-match). It reports build-side bucket overflow instead of silently corrupting rows. It sits between the partitioner/hash unit and the join-result writer, one instance per partition lane.

## Interface
- ROW_BITS, 3, log2 of bucket count; NUM_ROWS = 2**ROW_BITS
- SLOTS, 4, tuples per bucket (1..16)
- TUPLE_BITS, 64, tuple width; the key is bits [KEY_BITS-1:0]
- KEY_BITS, 32, compared key width (≤ TUPLE_BITS)
- SERIAL_BITS, 64, probe serial number width
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock
- resetn  in  1  asynchronous active-low reset
- in_valid_BUILD / in_ready_BUILD  in/out  1  build handshake
- in_data_BUILD  in  TUPLE_BITS  build tuple
- in_hash_BUILD  in  32  hash; row = [ROW_BITS-1:0]
- in_last_processed_BUILD  in  1  build stream finished (level)
- in_valid_PROBE / in_ready_PROBE  in/out  1  probe handshake
- in_data_PROBE  in  TUPLE_BITS  probe tuple
- in_hash_PROBE  in  32  hash; row = [ROW_BITS-1:0]
- in_serialnum  in  SERIAL_BITS  probe serial, echoed on output
- in_last_processed_PROBE  in  1  probe stream finished (level)
- out_valid / out_ready  out/in  1  result handshake
- out_data  out  2*TUPLE_BITS  {build tuple, probe tuple}; upper half zero on miss
- out_serialnum  out  SERIAL_BITS  serial of the probe producing this beat
- out_was_joined  out  1  1 = match beat, 0 = miss beat
- out_last_processed  out  1  sticky; all probes and results done
- overflow  out  1  sticky; a build tuple was dropped
- overflow_count  out  32  dropped build tuples, saturating at 2^32-1

## Operation
- Row layout: slot i at [i*TUPLE_BITS +: TUPLE_BITS]; fill count at top, width $clog2(SLOTS+1).
- Build-side tuples: at most SLOTS stored per row.
- States: CLEAR, B_IDLE, B_WR, P_IDLE, P_LOOK, P_EMIT, DONE.
- CLEAR: write zero to rows 0..NUM_ROWS-1, one row per cycle; both in_ready 0; then B_IDLE.
- B_IDLE: in_ready_BUILD=1. On accept, latch tuple and row, present raddr → B_WR. Else if in_last_processed_BUILD=1 and in_valid_BUILD=0 → P_IDLE.
- B_WR: in_ready_BUILD=0. If count<SLOTS, write tuple into slot[count] and count+1. Else no write, overflow←1, overflow_count+1 (saturating). → B_IDLE.
- P_IDLE: in_ready_PROBE=1. On accept, latch tuple, serial and row → P_LOOK. Else if in_last_processed_PROBE=1 and in_valid_PROBE=0 → DONE.
- P_LOOK: latch the row; match mask bit i = (i<count) & key equal → P_EMIT.
- P_EMIT: out_valid=1. One beat per set mask bit, ascending slot order, was_joined=1. Empty mask gives one miss beat, was_joined=0. Each beat advances only on out_valid&out_ready. After the final beat's handshake → P_IDLE.
- DONE: out_last_processed=1, all in_ready 0; held until reset.
- in_ready_* is 0 in every state not listed as asserting it.
- Reset at any time: asynchronous return to CLEAR; table is re-cleared; every output is 0 (out_data, out_serialnum, overflow_count all zero).

## Timing
- BRAM read latency is 1 cycle; same-row read-modify-write is serialised by B_WR, so no forwarding is needed.
- Clear: in_ready_BUILD first rises NUM_ROWS+1 cycles after resetn deasserts.
- Build throughput: 1 tuple per 2 cycles.
- Probe accepted in cycle T: first out_valid in T+2. With out_ready=1, n beats (n≥1) occupy T+2..T+1+n, and in_ready_PROBE reasserts at T+2+n.
- out_valid, out_data, out_serialnum and out_was_joined are registered. They stay stable while out_valid=1 and out_ready=0.
- out_last_processed rises in the cycle after DONE entry, never before the last beat's handshake.
- A last flag that arrives together with a valid tuple is honoured only after that tuple completes.

## Test plan
- Reset/clear: pulse resetn low mid-cycle → all outputs 0 immediately; in_ready_BUILD=0 for 9 cycles, then 1.
- Multi-match: build rows hash 5, keys 0x10,0x20,0x10 (tuples A,B,C); probe key 0x10, serial 7 → two beats {A,probe},{C,probe}, was_joined=1, serialnum=7.
- Miss: probe key 0x30, hash 5 → one beat, was_joined=0, out_data[127:64]=0.
- Overflow: 6 tuples into row 2 with SLOTS=4 → overflow=1, overflow_count=2. Probing a key shared by all six → exactly 4 beats.
- Backpressure: out_ready=0 for 5 cycles during P_EMIT → out_data stable, no beat lost or duplicated.
- Termination: build last, 3 probes, then probe last → out_last_processed=1 only after the 3rd probe's final beat handshake; in_ready_PROBE=0 thereafter.
